seq_mag_cmp: RTL
================

Name: seq_mag_cmp

Overview:
- Parametrised multi-cycle magnitude comparator; next generation of the team's 4-bit combinational comparator.
- Compares two WIDTH-bit operands CHUNK bits per cycle, most significant chunk first.
- Supports unsigned or two's-complement operands.
- Uses a start/ready/done handshake and registered, fully driven gt/lt/eq outputs (never high-Z), so it can sit on shared datapaths without a tristate bus.

Parameters:
- WIDTH, 16, operand width in bits; must be a multiple of CHUNK.
- CHUNK, 4, bits compared per cycle; 1 <= CHUNK <= WIDTH.
- SIGNED, 0, 0 = unsigned compare, 1 = two's-complement compare.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  synchronous reset, active-low.
- start  input  1  request a compare; accepted only when ready=1.
- a  input  WIDTH  operand A; sampled at the accepting edge only.
- b  input  WIDTH  operand B; sampled at the accepting edge only.
- ready  output  1  high in IDLE; block can accept start.
- done  output  1  one-cycle pulse; gt/lt/eq are valid and updated.
- gt  output  1  A > B; held from done until the next done.
- lt  output  1  A < B; held likewise.
- eq  output  1  A == B; held likewise.

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - state=IDLE.
  - ready=1, done=0, gt=lt=eq=0.
  - Chunk index and sticky flags cleared.
  - Reset mid-operation aborts the compare with no done pulse.
- Derived constant: NCHUNK = WIDTH/CHUNK.
- State machine:
  - IDLE:
    - ready=1.
    - start=1 at edge E: latch a,b; idx=NCHUNK-1; clear sticky; -> RUN.
  - RUN:
    - ready=0.
    - Each edge compares chunk idx of the latched operands.
    - On a differing chunk with sticky clear, set sticky and record chunk_gt/chunk_lt.
    - idx==0 -> DONE; otherwise idx decrements.
  - DONE:
    - done=1 for exactly this cycle; gt/lt/eq already registered.
    - Next edge -> IDLE; done=0.
- Result rules:
  - sticky set: gt/lt from the first (most significant) differing chunk.
  - sticky clear: eq=1.
  - Exactly one of gt/lt/eq is 1 after the first done.
- Signed mode (SIGNED=1):
  - MSB of the top chunk of both operands is inverted before comparison (offset-binary trick).
  - Lower chunks are compared unsigned.
- Latency, fixed: start accepted at edge E; done high in the cycle after edge E+NCHUNK. Next start is accepted at edge E+NCHUNK+2 at the earliest.
- start while ready=0 is ignored; it is not queued.
- a/b changes after the accepting edge have no effect.
- Outputs are never X or Z after reset.

Optional Feature:
- Macro: SEQ_MAG_CMP_EARLY_EXIT_EN.
- Defined: RUN goes to DONE on the first edge where a chunk differs. done then follows edge E+k, where k = chunks examined (1..NCHUNK). Equal operands still take NCHUNK.
- Undefined: fixed latency as above for all inputs; the sticky flag alone selects the result.

Decomposition:
- Shared package cmp_pkg (or include file):
  - State encoding localparams: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - Helper function for NCHUNK.
  - Elaboration check that WIDTH % CHUNK == 0.
- Sub-module cmp_chunk:
  - Combinational CHUNK-bit compare with outputs gt/lt (eq implied).
  - Parameter CHUNK; instanced once, fed by an index mux.
- FSM, latches and sticky logic stay in seq_mag_cmp.

Test Plan (WIDTH=16, CHUNK=4 unless noted):
- SIGNED=0, a=0x1234, b=0x1234, start at edge E -> done in cycle after E+4; eq=1, gt=lt=0; ready low for 5 cycles.
- SIGNED=0, a=0x9000, b=0x1000 -> gt=1. With EARLY_EXIT_EN, done after E+1; without it, after E+4.
- SIGNED=1, a=0x9000, b=0x1000 -> lt=1 (-28672 < 4096). Also a=0xFFFF, b=0x0000 -> lt=1.
- SIGNED=0, a=0x0001, b=0x0002 -> lt=1; done after E+4 in both builds (difference in the last chunk).
- start pulsed at E+2 during RUN with new operands -> ignored; first result unchanged, exactly one done pulse.
- rst_n=0 at E+2 during RUN -> next cycle ready=1, done=0, gt=lt=eq=0, no done pulse. A fresh compare after reset completes correctly. WIDTH=8/CHUNK=1 repeats the first four scenarios.

Source files
------------

// File: rtl/seq_mag_cmp_pkg.sv
// Shared definitions for the sequential magnitude comparator: state encoding,
// chunk-count helper and the parameter legality check used at elaboration.
package seq_mag_cmp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int num_chunks(input int width, input int chunk);
        return width / chunk;
    endfunction

    function automatic bit cfg_ok(input int width, input int chunk);
        return (chunk >= 1) && (chunk <= width) && ((width % chunk) == 0);
    endfunction

endpackage

// File: rtl/seq_mag_cmp_chunk.sv
// Combinational CHUNK-bit unsigned compare; equality is implied when
// neither gt nor lt is set.
module seq_mag_cmp_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    output logic             gt,
    output logic             lt
);

    assign gt = (a > b);
    assign lt = (a < b);

endmodule

// File: rtl/seq_mag_cmp.sv
// Multi-cycle magnitude comparator: walks the operands CHUNK bits per cycle,
// most significant chunk first. Define SEQ_MAG_CMP_EARLY_EXIT_EN to finish on the first differing chunk.
module seq_mag_cmp
    import seq_mag_cmp_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int CHUNK  = 4,
    parameter int SIGNED = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             done,
    output logic             gt,
    output logic             lt,
    output logic             eq
);

    localparam int NCHUNK = num_chunks(WIDTH, CHUNK);
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0]  LAST_IDX  = IDXW'(NCHUNK - 1);
    // Flipping the operand MSB maps two's-complement order onto unsigned order.
    localparam logic [WIDTH-1:0] SIGN_FLIP = (SIGNED != 0) ? (WIDTH'(1) << (WIDTH - 1)) : '0;

    if (!cfg_ok(WIDTH, CHUNK)) begin : g_bad_cfg
        $error("seq_mag_cmp: CHUNK must be 1..WIDTH and divide WIDTH");
    end

    state_t           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [IDXW-1:0]  idx;
    logic             sticky;
    logic             sticky_gt;
    logic             sticky_lt;

    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic             chunk_gt;
    logic             chunk_lt;
    logic             first_diff;
    logic             last_step;
    logic             res_gt;
    logic             res_lt;
    logic             res_eq;

    assign a_chunk = a_q[idx * CHUNK +: CHUNK];
    assign b_chunk = b_q[idx * CHUNK +: CHUNK];

    seq_mag_cmp_chunk #(
        .CHUNK(CHUNK)
    ) u_chunk (
        .a  (a_chunk),
        .b  (b_chunk),
        .gt (chunk_gt),
        .lt (chunk_lt)
    );

    assign first_diff = !sticky && (chunk_gt || chunk_lt);

`ifdef SEQ_MAG_CMP_EARLY_EXIT_EN
    assign last_step = (idx == '0) || first_diff;
`else
    assign last_step = (idx == '0);
`endif

    // The first differing chunk decides; later chunks cannot override it.
    assign res_gt = sticky ? sticky_gt : chunk_gt;
    assign res_lt = sticky ? sticky_lt : chunk_lt;
    assign res_eq = !sticky && !first_diff;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            ready     <= 1'b1;
            done      <= 1'b0;
            gt        <= 1'b0;
            lt        <= 1'b0;
            eq        <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            idx       <= '0;
            sticky    <= 1'b0;
            sticky_gt <= 1'b0;
            sticky_lt <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q       <= a ^ SIGN_FLIP;
                        b_q       <= b ^ SIGN_FLIP;
                        idx       <= LAST_IDX;
                        sticky    <= 1'b0;
                        sticky_gt <= 1'b0;
                        sticky_lt <= 1'b0;
                        ready     <= 1'b0;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    if (first_diff) begin
                        sticky    <= 1'b1;
                        sticky_gt <= chunk_gt;
                        sticky_lt <= chunk_lt;
                    end
                    if (last_step) begin
                        gt    <= res_gt;
                        lt    <= res_lt;
                        eq    <= res_eq;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        idx <= idx - 1'b1;
                    end
                end
                DONE: begin
                    ready <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    ready <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
